// File: rtl/aes128_rsm_inv_core.sv
// aes128_rsm_inv_core: iterative AES-128 decryption, one round per cycle,
// with rotating S-box masking enabled by the AES_RSM_MASK_EN macro.
module aes128_rsm_inv_core (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   i_rotate,
    input  logic [127:0] i_key,
    input  logic         i_key_valid,
    input  logic [127:0] i_ciphertext,
    input  logic         i_ciphertext_valid,
    output logic [127:0] o_plaintext,
    output logic         o_plaintext_valid,
    output logic         o_key_ready,
    output logic         o_busy
);

    typedef enum logic [1:0] {IDLE, KEYEXP, DEC, DONE} state_t;

`ifdef AES_RSM_MASK_EN
    localparam logic [127:0] MASKS =
        128'h000f3639_535c656a_959aa3ac_c6c9f0ff;
`else
    localparam logic [127:0] MASKS = '0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] mask_byte(input logic [3:0] j);
        return MASKS[8*(15-int'(j)) +: 8];
    endfunction

    // Byte i of the state carries mask m[(r + i) mod 16]
    function automatic logic [127:0] m_table(input logic [3:0] r);
        logic [127:0] m;
        logic [3:0]   k;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            k = r + 4'(i);
            m[8*(15-i) +: 8] = mask_byte(k);
        end
        return m;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*(15-(r+4*c)) +: 8] =
                    s[8*(15-(r+4*((c-r+4)%4))) +: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(15-4*c) +: 8];
            a1 = s[8*(14-4*c) +: 8];
            a2 = s[8*(13-4*c) +: 8];
            a3 = s[8*(12-4*c) +: 8];
            o[8*(15-4*c) +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                               ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[8*(14-4*c) +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                               ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[8*(13-4*c) +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                               ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[8*(12-4*c) +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                               ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Table j takes input masked by m[j] and returns output masked by m[j+1]
    function automatic logic [7:0] masked_inv_sbox(input logic [3:0] j,
                                                   input logic [7:0] x);
        return inv_sbox(x ^ mask_byte(j)) ^ mask_byte(j + 4'd1);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] key_inv(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] inv_rcon(input logic [7:0] r);
        return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
    endfunction

    // Mask rotates by one per round; the last round strips it entirely
    function automatic logic [127:0] dec_round(input logic [127:0] st,
                                               input logic [3:0]   rot,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [127:0] sh, sb, ark, mn;
        logic [3:0]   j;
        int           src;
        sh = inv_shift_rows(st);
        sb = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                src = r + 4 * ((c - r + 4) % 4);
                j = rot + 4'(src);
                sb[8*(15-(r+4*c)) +: 8] =
                    masked_inv_sbox(j, sh[8*(15-(r+4*c)) +: 8]);
            end
        ark = sb ^ rk;
        mn = m_table(rot + 4'd1);
        if (last) return ark ^ inv_shift_rows(mn);
        return inv_mix(ark) ^ inv_mix(inv_shift_rows(mn)) ^ mn;
    endfunction

    state_t       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] wkey_q, wkey_d;
    logic [7:0]   drcon_q, drcon_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rot_q, rot_d;
    logic         key_ready_q, key_ready_d;
    logic         valid_q, valid_d;
    logic [3:0]   rot_in, rot_step;
    logic [127:0] round_out;

`ifdef AES_RSM_MASK_EN
    assign rot_in   = i_rotate;
    assign rot_step = rot_q + 4'd1;
`else
    logic unused_rotate;
    assign unused_rotate = ^i_rotate;
    assign rot_in   = '0;
    assign rot_step = '0;
`endif

    assign round_out = dec_round(st_q, rot_q, wkey_q, cnt_q == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q       <= IDLE;
            cnt_q       <= '0;
            key_q       <= '0;
            rcon_q      <= '0;
            wkey_q      <= '0;
            drcon_q     <= '0;
            st_q        <= '0;
            rot_q       <= '0;
            key_ready_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            rcon_q      <= rcon_d;
            wkey_q      <= wkey_d;
            drcon_q     <= drcon_d;
            st_q        <= st_d;
            rot_q       <= rot_d;
            key_ready_q <= key_ready_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        rcon_d      = rcon_q;
        wkey_d      = wkey_q;
        drcon_d     = drcon_q;
        st_d        = st_q;
        rot_d       = rot_q;
        key_ready_d = key_ready_q;
        valid_d     = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (i_key_valid) begin
                    key_d       = i_key;
                    rcon_d      = 8'h01;
                    key_ready_d = 1'b0;
                    cnt_d       = '0;
                    fsm_d       = KEYEXP;
                end else if (i_ciphertext_valid && key_ready_q) begin
                    st_d    = i_ciphertext ^ key_q ^ m_table(rot_in);
                    wkey_d  = key_inv(key_q, 8'h36);
                    drcon_d = 8'h1b;
                    rot_d   = rot_in;
                    cnt_d   = '0;
                    fsm_d   = DEC;
                end
            end
            KEYEXP: begin
                key_d = key_fwd(key_q, rcon_q);
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d       = '0;
                    key_ready_d = 1'b1;
                    fsm_d       = IDLE;
                end else begin
                    rcon_d = xtime(rcon_q);
                end
            end
            DEC: begin
                st_d    = round_out;
                wkey_d  = key_inv(wkey_q, drcon_q);
                drcon_d = inv_rcon(drcon_q);
                rot_d   = rot_step;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    fsm_d   = DONE;
                end
            end
            DONE: fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    assign o_plaintext       = st_q;
    assign o_plaintext_valid = valid_q;
    assign o_key_ready       = key_ready_q;
    assign o_busy = (fsm_q != IDLE) | i_ciphertext_valid | i_key_valid;

endmodule

// File: tb/tb_aes128_rsm_inv_core.sv
// Bench for aes128_rsm_inv_core: directed FIPS-197 vectors, a scoreboard
// queue of expected plaintexts and a monitor checking value and cycle.
module tb_aes128_rsm_inv_core;

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K1X = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   i_rotate;
    logic [127:0] i_key;
    logic         i_key_valid;
    logic [127:0] i_ciphertext;
    logic         i_ciphertext_valid;
    logic [127:0] o_plaintext;
    logic         o_plaintext_valid;
    logic         o_key_ready;
    logic         o_busy;

    aes128_rsm_inv_core dut (
        .clk                (clk),
        .reset              (reset),
        .i_rotate           (i_rotate),
        .i_key              (i_key),
        .i_key_valid        (i_key_valid),
        .i_ciphertext       (i_ciphertext),
        .i_ciphertext_valid (i_ciphertext_valid),
        .o_plaintext        (o_plaintext),
        .o_plaintext_valid  (o_plaintext_valid),
        .o_key_ready        (o_key_ready),
        .o_busy             (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t sb_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_plaintext_valid === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stray_pulse pt=%h cyc=%0d",
                             o_plaintext, cyc);
                end else begin
                    e = sb_q.pop_front();
                    if (o_plaintext !== e.pt || cyc != e.due) begin
                        n_err++;
                        $display("FAIL pt_check got=%h@%0d exp=%h@%0d",
                                 o_plaintext, cyc, e.pt, e.due);
                    end
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic load_key(input logic [127:0] k, input string nm);
        i_key       = k;
        i_key_valid = 1'b1;
        tick();
        i_key_valid = 1'b0;
        repeat (9) tick();
        chk({nm, "_ready_e9"}, 128'(o_key_ready), 128'd0);
        tick();
        chk({nm, "_ready_e10"}, 128'(o_key_ready), 128'd1);
    endtask

    task automatic run_block(input logic [127:0] ct, input logic [3:0] rot,
                             input logic [127:0] pt, input bit expect_out,
                             input bit disturb);
        exp_t e;
        e.pt  = pt;
        e.due = cyc + 11;
        if (expect_out) sb_q.push_back(e);
        i_ciphertext       = ct;
        i_rotate           = rot;
        i_ciphertext_valid = 1'b1;
        tick();
        i_ciphertext_valid = 1'b0;
        chk("busy_run", 128'(o_busy), 128'd1);
        for (int k = 1; k <= 11; k++) begin
            if (disturb && k == 4) begin
                i_ciphertext       = 128'hdeadbeef;
                i_rotate           = 4'd9;
                i_ciphertext_valid = 1'b1;
            end
            tick();
            i_ciphertext_valid = 1'b0;
        end
    endtask

    initial begin
        reset              = 1'b1;
        i_rotate           = '0;
        i_key              = '0;
        i_key_valid        = 1'b0;
        i_ciphertext       = '0;
        i_ciphertext_valid = 1'b0;
        repeat (2) tick();
        chk("rst_pt", o_plaintext, 128'd0);
        chk("rst_valid", 128'(o_plaintext_valid), 128'd0);
        chk("rst_ready", 128'(o_key_ready), 128'd0);
        chk("rst_busy", 128'(o_busy), 128'd0);
        reset = 1'b0;
        tick();

        // Start with no key loaded must be dropped
        i_ciphertext       = C1;
        i_ciphertext_valid = 1'b1;
        tick();
        i_ciphertext_valid = 1'b0;
        repeat (12) tick();
        chk("nokey_pt", o_plaintext, 128'd0);
        chk("nokey_ready", 128'(o_key_ready), 128'd0);

        load_key(K1, "k1");
        chk("k10_value", dut.key_q, K1X);

        for (int r = 0; r < 16; r++)
            run_block(C1, 4'(r), P1, 1'b1, r == 7);
        repeat (3) tick();
        chk("pt_hold", o_plaintext, P1);

        // Key and start together: key wins, start dropped
        i_key              = K2;
        i_key_valid        = 1'b1;
        i_ciphertext       = C1;
        i_ciphertext_valid = 1'b1;
        tick();
        i_key_valid        = 1'b0;
        i_ciphertext_valid = 1'b0;
        chk("both_pt_hold", o_plaintext, P1);
        repeat (9) tick();
        chk("k2_ready_e9", 128'(o_key_ready), 128'd0);
        tick();
        chk("k2_ready_e10", 128'(o_key_ready), 128'd1);

        for (int b = 0; b < 3; b++)
            run_block(C2, 4'(3 * b + 1), P2, 1'b1, 1'b0);

        // Reset at round 5 of a run: no pulse may follow
        i_ciphertext       = C2;
        i_rotate           = 4'd2;
        i_ciphertext_valid = 1'b1;
        tick();
        i_ciphertext_valid = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_pt", o_plaintext, 128'd0);
        chk("mid_rst_valid", 128'(o_plaintext_valid), 128'd0);
        chk("mid_rst_ready", 128'(o_key_ready), 128'd0);
        chk("mid_rst_busy", 128'(o_busy), 128'd0);
        tick();
        reset = 1'b0;
        repeat (14) tick();
        chk("post_rst_ready", 128'(o_key_ready), 128'd0);
        chk("post_rst_pt", o_plaintext, 128'd0);

        load_key(K1, "reload");
        run_block(C1, 4'd9, P1, 1'b1, 1'b0);
        repeat (3) tick();
        chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
